// File: rtl/shift_timer_pkg.sv
// shift_timer_pkg: command and state encodings shared by the shift phase timer.
package shift_timer_pkg;
   typedef enum logic [1:0] {CMD_CLR, CMD_START, CMD_PAUSE, CMD_RESUME} cmd_t;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that saturates at rollover_val.
// rollover_flag marks the enabled edge on which the count will reach rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 5
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);
   logic [NUM_CNT_BITS-1:0] r_count;
   logic [NUM_CNT_BITS-1:0] w_inc;
   assign w_inc         = r_count + 1'b1;
   assign rollover_flag = count_enable && w_inc == rollover_val;
   assign count_out     = r_count;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst)
         r_count <= '0;
      else if (clear)
         r_count <= '0;
      else if (count_enable && r_count != rollover_val)
         r_count <= w_inc;
endmodule

// File: rtl/shift_phase_timer.sv
// shift_phase_timer: multi-phase shift-cycle timer with pause/resume,
// sticky per-phase done flags and a rejected-command error pulse.
module shift_phase_timer
   import shift_timer_pkg::*;
#(
   parameter int                            NUM_PHASES = 2,
   parameter int                            PH_W       = 1,
   parameter int                            CNT_WIDTH  = 5,
   parameter logic [NUM_PHASES*CNT_WIDTH-1:0] PHASE_LENS = {5'd16, 5'd8}
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cmd_valid,
   input  logic [1:0]            cmd,
   input  logic [PH_W-1:0]       cmd_phase,
   input  logic [CNT_WIDTH-1:0]  len_override,
   output logic                  busy,
   output logic                  paused,
   output logic [PH_W-1:0]       active_phase,
   output logic [CNT_WIDTH-1:0]  count,
   output logic [NUM_PHASES-1:0] done,
   output logic                  done_pulse,
   output logic                  err
);
   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_len;
   logic [PH_W-1:0]       r_phase;
   logic [NUM_PHASES-1:0] r_done;
   logic                  r_done_pulse;
   logic                  r_err;
   logic [CNT_WIDTH-1:0]  w_lens [NUM_PHASES];
   logic [CNT_WIDTH-1:0]  w_len;
   logic                  w_phase_ok, w_clr, w_start, w_start_ok, w_pause, w_resume, w_fin;
   for (genvar i = 0; i < NUM_PHASES; i++) begin : g_len
      assign w_lens[i] = PHASE_LENS[i*CNT_WIDTH +: CNT_WIDTH];
   end
   assign w_phase_ok = 32'(cmd_phase) < 32'(NUM_PHASES);
   assign w_len      = |len_override ? len_override : w_phase_ok ? w_lens[cmd_phase] : '0;
   assign w_clr      = cmd_valid && cmd == CMD_CLR;
   assign w_start    = cmd_valid && cmd == CMD_START;
   assign w_pause    = cmd_valid && cmd == CMD_PAUSE;
   assign w_resume   = cmd_valid && cmd == CMD_RESUME;
   assign w_start_ok = w_start && r_state == IDLE && w_phase_ok && |w_len;
   // Saturating counter; w_fin flags the edge on which count reaches the target
   flex_counter #(.NUM_CNT_BITS(CNT_WIDTH)) u_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (w_clr || w_start_ok),
      .count_enable (r_state == RUN),
      .rollover_val (r_len),
      .count_out    (count),
      .rollover_flag(w_fin)
   );
   // CLR beats completion, completion beats PAUSE
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_phase      <= '0;
         r_done       <= '0;
         r_done_pulse <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_err        <= w_start && !w_start_ok;
         r_done_pulse <= 1'b0;
         if (w_clr) begin
            r_state <= IDLE;
            r_done  <= '0;
         end else if (w_start_ok) begin
            r_state            <= RUN;
            r_len              <= w_len;
            r_phase            <= cmd_phase;
            r_done[cmd_phase]  <= 1'b0;
         end else if (r_state == RUN && w_fin) begin
            r_state          <= IDLE;
            r_done[r_phase]  <= 1'b1;
            r_done_pulse     <= 1'b1;
         end else if (r_state == RUN && w_pause)
            r_state <= HOLD;
         else if (r_state == HOLD && w_resume)
            r_state <= RUN;
      end
   assign busy         = r_state != IDLE;
   assign paused       = r_state == HOLD;
   assign active_phase = r_phase;
   assign done         = r_done;
   assign done_pulse   = r_done_pulse;
   assign err          = r_err;
endmodule

// File: tb/tb_shift_phase_timer.sv
// tb_shift_phase_timer: directed scenarios plus randomized commands checked
// cycle by cycle against a behavioural timer model.
module tb_shift_phase_timer;
   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'd0;
   logic       cmd_phase = 1'b0;
   logic [4:0] len_override = 5'd0;
   logic       busy, paused, active_phase, done_pulse, err;
   logic [4:0] count;
   logic [1:0] done;
   int n_tests = 0;
   int n_fail  = 0;
   int m_lens [2] = '{8, 16};
   bit m_busy, m_paused, m_pulse, m_err;
   int m_count, m_len, m_phase;
   bit [1:0] m_done;
   shift_phase_timer dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .cmd_phase   (cmd_phase),
      .len_override(len_override),
      .busy        (busy),
      .paused      (paused),
      .active_phase(active_phase),
      .count       (count),
      .done        (done),
      .done_pulse  (done_pulse),
      .err         (err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".busy"},   32'(busy),         32'(m_busy));
      check({tag, ".paused"}, 32'(paused),       32'(m_paused));
      check({tag, ".phase"},  32'(active_phase), m_phase);
      check({tag, ".count"},  32'(count),        m_count);
      check({tag, ".done"},   32'(done),         32'(m_done));
      check({tag, ".pulse"},  32'(done_pulse),   32'(m_pulse));
      check({tag, ".err"},    32'(err),          32'(m_err));
   endtask
   function automatic void model_reset();
      {m_busy, m_paused, m_pulse, m_err, m_done} = '0;
      m_count = 0; m_len = 0; m_phase = 0;
   endfunction
   // One clock edge of the timer rules applied to the command presented at that edge
   function automatic void model_edge(input bit v, input int c, input int p, input int o);
      int  l;
      bit  taken;
      m_err = 0; m_pulse = 0; taken = 0;
      if (v && c == 0) begin
         m_busy = 0; m_paused = 0; m_count = 0; m_done = 0; taken = 1;
      end else if (v && c == 1) begin
         l = (o != 0) ? o : (p < 2 ? m_lens[p] : 0);
         if (m_busy || p >= 2 || l == 0) m_err = 1;
         else begin
            m_busy = 1; m_paused = 0; m_count = 0; m_phase = p; m_len = l; m_done[p] = 0; taken = 1;
         end
      end
      if (!taken && m_busy && !m_paused) begin
         m_count++;
         if (m_count == m_len) begin
            m_done[m_phase] = 1; m_pulse = 1; m_busy = 0;
         end else if (v && c == 2) m_paused = 1;
      end else if (!taken && m_busy && m_paused && v && c == 3) m_paused = 0;
   endfunction
   task automatic step(input string tag, input bit v, input int c, input int p, input int o);
      @(negedge clk);
      cmd_valid = v; cmd = 2'(c); cmd_phase = 1'(p); len_override = 5'(o);
      @(posedge clk);
      model_edge(v, c, p, o);
      #1 check_all(tag);
   endtask
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31));
   endtask
   initial begin
      model_reset();
      #12 check_all("reset");
      @(negedge clk) n_rst = 1'b1;
      step("t1_start", 1, 1, 0, 0);
      idle("t1_run", 8);
      step("t2_start", 1, 1, 1, 0);
      idle("t2_run", 16);
      step("t3_start", 1, 1, 0, 3);
      step("t3_pause", 1, 2, 0, 0);
      idle("t3_hold", 3);
      step("t3_resume", 1, 3, 0, 0);
      idle("t3_run", 3);
      step("t4_start", 1, 1, 1, 0);
      idle("t4_run", 2);
      step("t4_busy", 1, 1, 0, 5);
      idle("t4_run2", 15);
      step("t5_start", 1, 1, 0, 2);
      step("t5_run", 0, 0, 0, 0);
      step("t5_clr_fin", 1, 0, 0, 0);
      step("t5_start2", 1, 1, 1, 6);
      step("t5_pause", 1, 2, 0, 0);
      step("t5_clr_hold", 1, 0, 0, 0);
      step("t5_pause_fin_s", 1, 1, 0, 2);
      step("t5_pause_fin_a", 0, 0, 0, 0);
      step("t5_pause_fin_b", 1, 2, 0, 0);
      step("t5_resume_idle", 1, 3, 0, 0);
      step("t6_start", 1, 1, 1, 0);
      idle("t6_run", 5);
      #3 n_rst = 1'b0;
      model_reset();
      #1 check_all("t6_async");
      @(negedge clk) n_rst = 1'b1;
      step("t6_start2", 1, 1, 0, 0);
      idle("t6_run2", 8);
      for (int i = 0; i < 600; i++) begin
         int c, o;
         c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
         o = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
         step("rand", $urandom_range(0, 1) == 1, c, $urandom_range(0, 1), o);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
